gpio_axil_bank: RTL and testbench

Parametrised AXI4-Lite GPIO bank, the successor to the fixed 32-pin GPIO peripheral on the SoC config bus. Adds configurable pin count, multi-stage input synchronisation, atomic output set/clear/toggle, per-pin edge/level/any-edge interrupts with W1C status, and an optional per-pin debounce filter. One instance sits on the peripheral AXI-Lite fabric and drives one pad bank.

---
 rtl/gpio_axil_pkg.sv | 39 +++
 rtl/gpio_axil_bank_in_filter.sv | 62 ++++++
 rtl/gpio_axil_bank.sv | 192 +++++++++++++++++++
 tb/tb_gpio_axil_bank.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_axil_pkg.sv
// Shared constants for the AXI-Lite GPIO bank: register word offsets, response codes, PARAMS fields.
package gpio_axil_pkg;

  localparam logic [5:0] REG_DIR        = 6'h00;
  localparam logic [5:0] REG_INPUT      = 6'h01;
  localparam logic [5:0] REG_OUTPUT     = 6'h02;
  localparam logic [5:0] REG_OUT_SET    = 6'h03;
  localparam logic [5:0] REG_OUT_CLR    = 6'h04;
  localparam logic [5:0] REG_INT_MASK   = 6'h05;
  localparam logic [5:0] REG_OUT_TGL    = 6'h06;
  localparam logic [5:0] REG_INT_CLR    = 6'h07;
  localparam logic [5:0] REG_INT_STATUS = 6'h08;
  localparam logic [5:0] REG_INT_POL    = 6'h09;
  localparam logic [5:0] REG_INT_MODE   = 6'h0A;
  localparam logic [5:0] REG_INT_ANY    = 6'h0B;
  localparam logic [5:0] REG_DEBOUNCE   = 6'h0C;
  localparam logic [5:0] REG_PARAMS     = 6'h0D;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int PARAMS_WIDTH_LSB = 0;
  localparam int PARAMS_WIDTH_W   = 6;
  localparam int PARAMS_DB_BIT    = 8;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

  function automatic logic is_mapped(input logic [5:0] idx);
    return idx <= REG_PARAMS;
  endfunction

endpackage

// File: rtl/gpio_axil_bank_in_filter.sv
// Per-pin input synchroniser with optional debounce (GPIO_DEBOUNCE_EN) for the GPIO bank.
module gpio_axil_in_filter
  import gpio_axil_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [DB_W-1:0]  db_limit_i,
  output logic [WIDTH-1:0] filt_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_W-1:0]  cnt_q [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // Up-counter compared against the live limit so a DEBOUNCE rewrite applies to running counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= '0;
      for (int p = 0; p < WIDTH; p++) cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < WIDTH; p++) begin
        if (sync_out[p] != filt_q[p]) begin
          if (cnt_q[p] >= db_limit_i) begin
            filt_q[p] <= sync_out[p];
            cnt_q[p]  <= '0;
          end else begin
            cnt_q[p] <= cnt_q[p] + DB_W'(1);
          end
        end else begin
          cnt_q[p] <= '0;
        end
      end
    end
  end

  assign filt_o = filt_q;
`else
  logic unused_db;
  assign unused_db = ^db_limit_i;
  assign filt_o    = sync_out;
`endif

endmodule

// File: rtl/gpio_axil_bank.sv
// AXI4-Lite GPIO bank: direction/output registers, atomic set/clear/toggle, per-pin interrupts.
// Optional per-pin debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_axil_bank
  import gpio_axil_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_awvalid_i,
  input  logic [31:0]      cfg_awaddr_i,
  input  logic             cfg_wvalid_i,
  input  logic [31:0]      cfg_wdata_i,
  input  logic [3:0]       cfg_wstrb_i,
  input  logic             cfg_bready_i,
  input  logic             cfg_arvalid_i,
  input  logic [31:0]      cfg_araddr_i,
  input  logic             cfg_rready_i,
  output logic             cfg_awready_o,
  output logic             cfg_wready_o,
  output logic             cfg_bvalid_o,
  output logic [1:0]       cfg_bresp_o,
  output logic             cfg_arready_o,
  output logic             cfg_rvalid_o,
  output logic [31:0]      cfg_rdata_o,
  output logic [1:0]       cfg_rresp_o,
  input  logic [WIDTH-1:0] gpio_input_i,
  output logic [WIDTH-1:0] gpio_output_o,
  output logic [WIDTH-1:0] gpio_output_enable_o,
  output logic             intr_o
);

  logic             awready_q, arready_q, bvalid_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;
  logic             wr_hs, rd_hs;
  logic [5:0]       wr_idx, rd_idx;
  logic [31:0]      wmask32;
  logic [WIDTH-1:0] wkeep, wbits, clr_bits;
  logic [31:0]      rd_data;
  logic [1:0]       rd_resp;

  logic [WIDTH-1:0] dir_q, out_q, mask_q, pol_q, mode_q, any_q, status_q, prev_q;
  logic             intr_q;
  logic [WIDTH-1:0] filt, rise, fall, edge_evt, lvl_evt, evt;
  logic [DB_W-1:0]  db_q;
  logic             db_present;

  assign wr_hs   = awready_q & cfg_awvalid_i & cfg_wvalid_i;
  assign rd_hs   = arready_q & cfg_arvalid_i;
  assign wr_idx  = cfg_awaddr_i[7:2];
  assign rd_idx  = cfg_araddr_i[7:2];
  assign wmask32 = strb_to_mask(cfg_wstrb_i);
  assign wkeep   = wmask32[WIDTH-1:0];
  assign wbits   = cfg_wdata_i[WIDTH-1:0] & wkeep;
  assign clr_bits = (wr_hs && wr_idx == REG_INT_CLR) ? wbits : '0;

  logic unused_in;
  assign unused_in = ^{cfg_awaddr_i[31:8], cfg_awaddr_i[1:0], cfg_araddr_i[31:8],
                       cfg_araddr_i[1:0], cfg_wdata_i, wmask32};

  // Ready is registered so the bus outputs are clean flops; each pulses for one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      awready_q <= cfg_awvalid_i & cfg_wvalid_i & ~bvalid_q & ~awready_q;
      arready_q <= cfg_arvalid_i & ~rvalid_q & ~arready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= is_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
      end else if (cfg_bready_i) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (cfg_rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  gpio_axil_in_filter #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .DB_W       (DB_W)
  ) u_in_filter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pad_i     (gpio_input_i),
    .db_limit_i(db_q),
    .filt_o    (filt)
  );

  assign rise     = filt & ~prev_q;
  assign fall     = ~filt & prev_q;
  assign edge_evt = (any_q & (filt ^ prev_q)) | (~any_q & pol_q & rise) | (~any_q & ~pol_q & fall);
  assign lvl_evt  = ~(filt ^ pol_q);
  assign evt      = (mode_q & edge_evt) | (~mode_q & lvl_evt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q    <= '0;
      out_q    <= '0;
      mask_q   <= '0;
      pol_q    <= '0;
      mode_q   <= '0;
      any_q    <= '0;
      status_q <= '0;
      prev_q   <= '0;
      intr_q   <= 1'b0;
    end else begin
      prev_q   <= filt;
      // A new event in the same cycle as a clear keeps the bit set.
      status_q <= (status_q & ~clr_bits) | evt;
      intr_q   <= |(status_q & mask_q);
      if (wr_hs) begin
        case (wr_idx)
          REG_DIR:      dir_q  <= (dir_q & ~wkeep) | wbits;
          REG_OUTPUT:   out_q  <= (out_q & ~wkeep) | wbits;
          REG_OUT_SET:  out_q  <= out_q | wbits;
          REG_OUT_CLR:  out_q  <= out_q & ~wbits;
          REG_OUT_TGL:  out_q  <= out_q ^ wbits;
          REG_INT_MASK: mask_q <= (mask_q & ~wkeep) | wbits;
          REG_INT_POL:  pol_q  <= (pol_q & ~wkeep) | wbits;
          REG_INT_MODE: mode_q <= (mode_q & ~wkeep) | wbits;
          REG_INT_ANY:  any_q  <= (any_q & ~wkeep) | wbits;
          default: ;
        endcase
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  assign db_present = 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q <= '0;
    end else if (wr_hs && wr_idx == REG_DEBOUNCE) begin
      db_q <= (db_q & ~wmask32[DB_W-1:0]) | (cfg_wdata_i[DB_W-1:0] & wmask32[DB_W-1:0]);
    end
  end
`else
  assign db_present = 1'b0;
  assign db_q       = '0;
`endif

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      REG_DIR:        rd_data[WIDTH-1:0] = dir_q;
      REG_INPUT:      rd_data[WIDTH-1:0] = filt;
      REG_OUTPUT:     rd_data[WIDTH-1:0] = out_q;
      REG_OUT_SET, REG_OUT_CLR, REG_OUT_TGL, REG_INT_CLR: rd_data = '0;
      REG_INT_MASK:   rd_data[WIDTH-1:0] = mask_q;
      REG_INT_STATUS: rd_data[WIDTH-1:0] = status_q;
      REG_INT_POL:    rd_data[WIDTH-1:0] = pol_q;
      REG_INT_MODE:   rd_data[WIDTH-1:0] = mode_q;
      REG_INT_ANY:    rd_data[WIDTH-1:0] = any_q;
      REG_DEBOUNCE:   rd_data[DB_W-1:0]  = db_q;
      REG_PARAMS: begin
        rd_data[PARAMS_WIDTH_LSB +: PARAMS_WIDTH_W] = PARAMS_WIDTH_W'(WIDTH);
        rd_data[PARAMS_DB_BIT]                      = db_present;
      end
      default:        rd_resp = RESP_SLVERR;
    endcase
  end

  assign cfg_awready_o        = awready_q;
  assign cfg_wready_o         = awready_q;
  assign cfg_bvalid_o         = bvalid_q;
  assign cfg_bresp_o          = bresp_q;
  assign cfg_arready_o        = arready_q;
  assign cfg_rvalid_o         = rvalid_q;
  assign cfg_rdata_o          = rdata_q;
  assign cfg_rresp_o          = rresp_q;
  assign gpio_output_o        = out_q;
  assign gpio_output_enable_o = dir_q;
  assign intr_o               = intr_q;

endmodule

// File: tb/tb_gpio_axil_bank.sv
// Self-checking bench for gpio_axil_bank; expectations adapt to GPIO_DEBOUNCE_EN.
module tb_gpio_axil_bank;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int DB_W  = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB_ON = 1;
`else
  localparam int DB_ON = 0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] mask;
    logic [1:0]  resp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic             arvalid = 1'b0, rready = 1'b0;
  logic [31:0]      awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]       wstrb = '0;
  logic             awready, wready, bvalid, arready, rvalid;
  logic [1:0]       bresp, rresp;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out, gpio_oe;
  logic             intr;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  gpio_axil_bank #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DB_W(DB_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_awvalid_i(awvalid), .cfg_awaddr_i(awaddr), .cfg_wvalid_i(wvalid),
    .cfg_wdata_i(wdata), .cfg_wstrb_i(wstrb), .cfg_bready_i(bready),
    .cfg_arvalid_i(arvalid), .cfg_araddr_i(araddr), .cfg_rready_i(rready),
    .cfg_awready_o(awready), .cfg_wready_o(wready), .cfg_bvalid_o(bvalid),
    .cfg_bresp_o(bresp), .cfg_arready_o(arready), .cfg_rvalid_o(rvalid),
    .cfg_rdata_o(rdata), .cfg_rresp_o(rresp),
    .gpio_input_i(gpio_in), .gpio_output_o(gpio_out),
    .gpio_output_enable_o(gpio_oe), .intr_o(intr)
  );

  task automatic push_exp(input logic [31:0] d, input logic [31:0] m, input logic [1:0] r,
                          input string nm);
    exp_t e;
    e.data = d; e.mask = m; e.resp = r;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) begin
      checks++; errors++;
      $display("FAIL write_timeout addr %h: awready 0, want 1", a);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL bvalid_timeout addr %h: bvalid 0, want 1", a);
      return;
    end
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    d = 'x; r = 2'bxx;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) begin
      checks++; errors++;
      $display("FAIL read_timeout addr %h: arready 0, want 1", a);
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout addr %h: rvalid 0, want 1", a);
      return;
    end
    d = rdata; r = rresp;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; exp_t e; string nm;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gpio_out, gpio_oe, intr} !== '0) begin
      errors++;
      $display("FAIL reset_pads: got out %h oe %h intr %b, want all 0", gpio_out, gpio_oe, intr);
    end
    checks++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got %b%b%b %b %b%b %b %h, want all 0",
               awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(32'(WIDTH) | (32'(DB_ON) << 8), '1, 2'b00, "params");
    push_exp(32'h0, '1, 2'b00, "dir_reset");
    for (int i = 0; i < 2; i++) begin
      axi_read(i == 0 ? 32'h34 : 32'h00, d, r);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
        errors++;
        $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_output_ops();
    logic [31:0] d, model; logic [1:0] r; exp_t e; string nm;
    model = 32'h0000_FFFF;          wr(32'h08, 32'h0000_FFFF);
    model = model | 32'hFF00_0000;  wr(32'h0C, 32'hFF00_0000);
    model = model & ~32'h0000_000F; wr(32'h10, 32'h0000_000F);
    model = model ^ 32'h0000_0011;  wr(32'h18, 32'h0000_0011);
    checks++;
    if (gpio_out !== model) begin
      errors++; $display("FAIL gpio_out_ops: got %h, want %h", gpio_out, model);
    end
    wr(32'h00, 32'hA5A5_0F0F);
    checks++;
    if (gpio_oe !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL gpio_oe: got %h, want %h", gpio_oe, 32'hA5A5_0F0F);
    end
    push_exp(model, '1, 2'b00, "output_ops");
    push_exp(32'h0, '1, 2'b00, "out_set_reads0");
    for (int i = 0; i < 2; i++) begin
      axi_read(i == 0 ? 32'h08 : 32'h0C, d, r);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
        errors++;
        $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_strobe_and_errors();
    logic [31:0] d; logic [1:0] r; exp_t e; string nm;
    logic [31:0] addrs [3];
    wr(32'h08, 32'h0);
    axi_write(32'h08, 32'hFFFF_FFFF, 4'b0011, r);
    push_exp(32'h0000_FFFF, '1, 2'b00, "strobe_low");
    axi_write(32'h0C, 32'hFFFF_FFFF, 4'b0100, r);
    push_exp(32'h00FF_FFFF, '1, 2'b00, "strobe_set");
    push_exp(32'h0, '1, 2'b10, "unmapped_read");
    addrs[0] = 32'h08; addrs[1] = 32'h08; addrs[2] = 32'h40;
    // Reads run after both writes; each expectation reflects state at its read.
    e = sb_q.pop_front(); sb_q.push_front(e);
    for (int i = 1; i < 3; i++) begin
      axi_read(addrs[i], d, r);
      if (i == 1) begin
        e = sb_q.pop_front(); nm = nm_q.pop_front();
      end
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
        errors++;
        $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
      end
    end
    push_exp(32'h0, 32'h0, 2'b10, "unmapped_write");
    axi_write(32'h40, 32'h1234_5678, 4'hF, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (r !== e.resp) begin
      errors++; $display("FAIL %s: got resp %0d, want resp %0d", nm, r, e.resp);
    end
    push_exp(32'h0, 32'h0, 2'b00, "ro_write_okay");
    axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (r !== e.resp) begin
      errors++; $display("FAIL %s: got resp %0d, want resp %0d", nm, r, e.resp);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d; logic [1:0] r; exp_t e; string nm; int n;
    gpio_in[0] = 1'b0;
    wr(32'h28, 32'h1);
    wr(32'h24, 32'h1);
    repeat (6) @(negedge clk);
    wr(32'h1C, 32'hFFFF_FFFF);
    wr(32'h14, 32'h1);
    repeat (3) @(negedge clk);
    checks++;
    if (intr !== 1'b0) begin
      errors++; $display("FAIL edge_idle_intr: got %b, want 0", intr);
    end
    gpio_in[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!intr && n < 20);
    checks++;
    if (n != SYNC + 2 + DB_ON) begin
      errors++; $display("FAIL edge_latency: got %0d cycles, want %0d", n, SYNC + 2 + DB_ON);
    end
    push_exp(32'h1, 32'h1, 2'b00, "edge_status_set");
    axi_read(32'h20, d, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
      errors++;
      $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
    end
    wr(32'h1C, 32'h1);
    checks++;
    if (intr !== 1'b0) begin
      errors++; $display("FAIL edge_clr_intr: got %b, want 0", intr);
    end
    repeat (10) @(negedge clk);
    push_exp(32'h0, 32'h1, 2'b00, "edge_no_retrigger");
    axi_read(32'h20, d, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (((d & e.mask) !== e.data) || (r !== e.resp) || intr !== 1'b0) begin
      errors++;
      $display("FAIL %s: got %h intr %b, want %h intr 0", nm, d & e.mask, intr, e.data);
    end
  endtask

  task automatic test_level_irq();
    logic [31:0] d; logic [1:0] r; exp_t e; string nm;
    wr(32'h24, 32'h9);
    gpio_in[3] = 1'b1;
    repeat (8) @(negedge clk);
    wr(32'h1C, 32'h8);
    push_exp(32'h8, 32'h8, 2'b00, "level_persist");
    axi_read(32'h20, d, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
      errors++;
      $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
    end
    gpio_in[3] = 1'b0;
    repeat (8) @(negedge clk);
    wr(32'h1C, 32'h8);
    push_exp(32'h0, 32'h8, 2'b00, "level_cleared");
    axi_read(32'h20, d, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
      errors++;
      $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d; logic [1:0] r; exp_t e; string nm;
    logic [31:0] addrs [2];
    wr(32'h30, 32'h4);
    wr(32'h28, 32'h21);
    wr(32'h2C, 32'h20);
    push_exp(DB_ON != 0 ? 32'h4 : 32'h0, '1, 2'b00, "debounce_reg");
    axi_read(32'h30, d, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
      errors++;
      $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
    end
    repeat (10) @(negedge clk);
    wr(32'h1C, 32'hFFFF_FFFF);
    gpio_in[5] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[5] = 1'b0;
    repeat (12) @(negedge clk);
    push_exp(32'h0, 32'h20, 2'b00, "glitch_input");
    push_exp(DB_ON != 0 ? 32'h0 : 32'h20, 32'h20, 2'b00, "glitch_status");
    addrs[0] = 32'h04; addrs[1] = 32'h20;
    for (int i = 0; i < 2; i++) begin
      axi_read(addrs[i], d, r);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
        errors++;
        $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
      end
    end
    wr(32'h1C, 32'h20);
    gpio_in[5] = 1'b1;
    repeat (6) @(negedge clk);
    gpio_in[5] = 1'b0;
    repeat (15) @(negedge clk);
    push_exp(32'h20, 32'h20, 2'b00, "pulse_status");
    axi_read(32'h20, d, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
      errors++;
      $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
    end
    gpio_in[5] = 1'b1;
    repeat (15) @(negedge clk);
    push_exp(32'h20, 32'h20, 2'b00, "held_input");
    axi_read(32'h04, d, r);
    e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
      errors++;
      $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r, wr_r; exp_t e; string nm;
    wr(32'h08, 32'h1111_0000);
    push_exp(32'h1111_0000, '1, 2'b00, "same_cycle_old");
    push_exp(32'h2222_0000, '1, 2'b00, "after_write_new");
    fork
      axi_write(32'h08, 32'h2222_0000, 4'hF, wr_r);
      axi_read(32'h08, d, r);
    join
    for (int i = 0; i < 2; i++) begin
      if (i == 1) axi_read(32'h08, d, r);
      e = sb_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (((d & e.mask) !== e.data) || (r !== e.resp)) begin
        errors++;
        $display("FAIL %s: got %h resp %0d, want %h resp %0d", nm, d & e.mask, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL abort_rvalid: got %b, want 0", rvalid);
    end
    checks++;
    if (gpio_out !== '0 || intr !== 1'b0) begin
      errors++; $display("FAIL abort_regs: got out %h intr %b, want 0 0", gpio_out, intr);
    end
    rready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_output_ops();
    test_strobe_and_errors();
    test_edge_irq();
    test_level_irq();
    test_debounce();
    test_same_cycle();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, want finished");
    $fatal(1, "watchdog");
  end

endmodule
